hex_display_scanner: RTL

- Upstream feeder for the per-digit hex-to-7-segment decoder.
- Holds a multi-digit hex value and time-multiplexes it onto one shared decoder, one digit per refresh slot.
- Drives the active-low digit-select lines, a per-digit blank request for leading-zero suppression, and a frame-commit strobe.
- New values are committed only at frame boundaries, so a displayed frame never mixes old and new digits (no tearing).

---
 rtl/hex_display_scanner_if.sv | 23 ++
 rtl/hex_display_scanner.sv | 94 +++++++++
 2 files changed

// File: rtl/hex_display_scanner_if.sv
// Bundles the value-load request and the per-slot display outputs of hex_display_scanner.
// master drives load/value/blank_lz and observes the scan outputs; slave is the scanner.
interface hex_display_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic                    blank_lz;
  logic [3:0]              hex_digit;
  logic                    digit_blank;
  logic [NUM_DIGITS-1:0]   anode_n;
  logic                    frame_commit;

  modport master (
    output load, value, blank_lz,
    input  hex_digit, digit_blank, anode_n, frame_commit
  );

  modport slave (
    input  load, value, blank_lz,
    output hex_digit, digit_blank, anode_n, frame_commit
  );
endinterface

// File: rtl/hex_display_scanner.sv
// Time-multiplexes a multi-digit hex value onto one decoder; new values latch only at frame boundaries.
// Latency: digit select moves the cycle after each tick; loads show by the next frame. Never stalls load.
module hex_display_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input logic               clk,
  input logic               rst_n,
  hex_display_scanner_if.slave bus
);
  localparam int VW = 4 * NUM_DIGITS;
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);

  logic [PW-1:0] presc;
  logic [IW-1:0] idx;
  logic [VW-1:0] disp_reg;
  logic [VW-1:0] pend_reg;
  logic          pending;
  logic          frame_commit_q;
  logic          blank_q;
  logic          tick;
  logic          boundary;

  assign tick     = (presc == PRESC_MAX);
  assign boundary = tick && (idx == IDX_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc          <= '0;
      idx            <= '0;
      disp_reg       <= '0;
      pend_reg       <= '0;
      pending        <= 1'b0;
      frame_commit_q <= 1'b0;
      blank_q        <= 1'b0;
    end else begin
      presc          <= tick ? '0 : presc + 1'b1;
      frame_commit_q <= 1'b0;
      // blank_lz is registered so no output depends combinationally on an input
      blank_q        <= bus.blank_lz;
      if (tick) begin
        idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      end
      if (boundary) begin
        if (bus.load) begin
          disp_reg       <= bus.value;
          pending        <= 1'b0;
          frame_commit_q <= 1'b1;
        end else if (pending) begin
          disp_reg       <= pend_reg;
          pending        <= 1'b0;
          frame_commit_q <= 1'b1;
        end
      end else if (bus.load) begin
        pend_reg <= bus.value;
        pending  <= 1'b1;
      end
    end
  end

  logic [3:0]            cur_nib;
  logic [NUM_DIGITS-1:0] upper_zero;
  logic [NUM_DIGITS-1:0] anode_dec;
  logic                  cur_upper_zero;
  logic                  zero_acc;

  always_comb begin
    cur_nib        = 4'h0;
    upper_zero     = '0;
    anode_dec      = '1;
    cur_upper_zero = 1'b0;
    zero_acc       = 1'b1;
    // upper_zero[i] is set when digit i and every digit to its left are zero
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_acc      = zero_acc && (disp_reg[4*i +: 4] == 4'h0);
      upper_zero[i] = zero_acc;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib        = disp_reg[4*i +: 4];
        anode_dec[i]   = 1'b0;
        cur_upper_zero = upper_zero[i];
      end
    end
  end

  assign bus.hex_digit    = cur_nib;
  assign bus.anode_n      = anode_dec;
  assign bus.digit_blank  = blank_q && (idx != '0) && cur_upper_zero;
  assign bus.frame_commit = frame_commit_q;
endmodule
